// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin sharing of one I2C master between NREQ requesters
//   clk, reset_n                 : clock, async active-low reset
//   req_valid/addr/cmd/wdata     : per-requester request (8-bit slices)
//   req_ready, rsp_valid         : one-hot accept / completion pulses
//   rsp_rdata/nack/timeout       : completion result, held until next completion
//   i2c_addr/cmd/tx_data/trigger : captured operands and start level to the master
//   i2c_busy/rx_data/ack         : status and result from the master
module i2c_txn_arbiter #(
    parameter int NREQ = 2,
    parameter int TIMEOUT_W = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = {TIMEOUT_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_cmd,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_nack,
    output logic              rsp_timeout,
    output logic [7:0]        i2c_addr,
    output logic [7:0]        i2c_cmd,
    output logic [7:0]        i2c_tx_data,
    output logic              i2c_trigger,
    input  logic              i2c_busy,
    input  logic [7:0]        i2c_rx_data,
    input  logic              i2c_ack
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, RUN, RESP} state_t;
    state_t state_q, state_d;
    logic busy_m_q, busy_s_q, found, grant, expired;
    logic [PW-1:0] ptr_q, ptr_d, owner_q, owner_d, gnt;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic [7:0] addr_q, addr_d, cmd_q, cmd_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic nack_q, nack_d, tmo_q, tmo_d;
    always_comb begin
        found = 1'b0;
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[(int'(ptr_q) + i) % NREQ]) begin
                found = 1'b1;
                gnt = PW'((int'(ptr_q) + i) % NREQ);
            end
        end
    end
    assign grant = (state_q == IDLE) && !busy_s_q && found;
    assign expired = wd_q == TIMEOUT_CYC;
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        owner_d = owner_q;
        wd_d = wd_q;
        addr_d = addr_q;
        cmd_d = cmd_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        nack_d = nack_q;
        tmo_d = tmo_q;
        case (state_q)
            IDLE: if (grant) begin
                state_d = ISSUE;
                ptr_d = (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
                owner_d = gnt;
                addr_d = req_addr[gnt*8 +: 8];
                cmd_d = req_cmd[gnt*8 +: 8];
                wdata_d = req_wdata[gnt*8 +: 8];
                wd_d = '0;
            end
            // busy is checked before expiry so a late-but-simultaneous start is not aborted
            ISSUE: if (busy_s_q) begin
                state_d = RUN;
                wd_d = '0;
            end else if (expired) state_d = RESP;
            else wd_d = wd_q + 1'b1;
            RUN: if (!busy_s_q || expired) state_d = RESP;
            else wd_d = wd_q + 1'b1;
            RESP: begin
                state_d = IDLE;
                wd_d = '0;
            end
            default: state_d = IDLE;
        endcase
        // result registers load on entry to RESP so they are valid alongside rsp_valid
        if (state_d == RESP && state_q != RESP) begin
            rdata_d = addr_q[0] ? i2c_rx_data : 8'h00;
            nack_d = i2c_ack;
            tmo_d = (state_q == ISSUE) || busy_s_q;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy_m_q <= 1'b0;
            busy_s_q <= 1'b0;
            ptr_q <= '0;
            owner_q <= '0;
            wd_q <= '0;
            addr_q <= '0;
            cmd_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            nack_q <= 1'b0;
            tmo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_m_q <= i2c_busy;
            busy_s_q <= busy_m_q;
            ptr_q <= ptr_d;
            owner_q <= owner_d;
            wd_q <= wd_d;
            addr_q <= addr_d;
            cmd_q <= cmd_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            nack_q <= nack_d;
            tmo_q <= tmo_d;
        end
    end
    // reset_n gates the combinational grant so no accept is signalled while in reset
    assign req_ready = (grant && reset_n) ? NREQ'(1) << gnt : '0;
    assign rsp_valid = (state_q == RESP) ? NREQ'(1) << owner_q : '0;
    assign i2c_trigger = state_q == ISSUE;
    assign i2c_addr = addr_q;
    assign i2c_cmd = cmd_q;
    assign i2c_tx_data = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_nack = nack_q;
    assign rsp_timeout = tmo_q;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: directed vector bench for i2c_txn_arbiter with a behavioural I2C master
module tb_i2c_txn_arbiter;
    logic clk = 1'b0, reset_n = 1'b0;
    logic [1:0] req_valid = '0;
    logic [15:0] req_addr = '0, req_cmd = '0, req_wdata = '0;
    logic [1:0] req_ready, rsp_valid;
    logic [7:0] rsp_rdata, i2c_addr, i2c_cmd, i2c_tx_data;
    logic rsp_nack, rsp_timeout, i2c_trigger, i2c_busy;
    logic [7:0] i2c_rx_data = '0;
    logic i2c_ack = 1'b0;
    logic model_busy = 1'b0, busy_force = 1'b0;
    logic [7:0] model_rx = '0;
    logic model_ack = 1'b0;
    int mode = 0;
    int checks = 0, errors = 0;

    assign i2c_busy = model_busy | busy_force;

    i2c_txn_arbiter #(.NREQ(2), .TIMEOUT_W(24), .TIMEOUT_CYC(24'd16)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_cmd(req_cmd), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout),
        .i2c_addr(i2c_addr), .i2c_cmd(i2c_cmd), .i2c_tx_data(i2c_tx_data),
        .i2c_trigger(i2c_trigger), .i2c_busy(i2c_busy), .i2c_rx_data(i2c_rx_data), .i2c_ack(i2c_ack)
    );

    always #5 clk = ~clk;

    // mode 0: raise busy 2 clk after trigger, hold 10 clk, then present rx/ack
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mode == 0 && i2c_trigger && !model_busy) begin
                repeat (2) @(posedge clk);
                #1 model_busy = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                i2c_rx_data = model_rx;
                i2c_ack = model_ack;
                model_busy = 1'b0;
            end
        end
    end

    typedef struct {
        logic [1:0] rv;
        logic [7:0] a0, c0, w0, a1, c1, w1, rx;
        logic ack;
        logic [1:0] eready;
        logic [7:0] erdata;
        logic enack;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready != 0) break;
        end
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid != 0) break;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int g;
        logic [7:0] ea, ec, ew;
        req_valid = v.rv;
        req_addr = {v.a1, v.a0};
        req_cmd = {v.c1, v.c0};
        req_wdata = {v.w1, v.w0};
        model_rx = v.rx;
        model_ack = v.ack;
        g = v.eready[1] ? 1 : 0;
        ea = g ? v.a1 : v.a0;
        ec = g ? v.c1 : v.c0;
        ew = g ? v.w1 : v.w0;
        wait_ready();
        chk("req_ready", {30'd0, req_ready}, {30'd0, v.eready});
        @(posedge clk);
        #1;
        req_valid[g] = 1'b0;
        req_addr[g*8 +: 8] = ~ea;
        req_cmd[g*8 +: 8] = ~ec;
        req_wdata[g*8 +: 8] = ~ew;
        @(negedge clk);
        chk("trigger_issue", {31'd0, i2c_trigger}, 32'd1);
        chk("i2c_addr_cap", {24'd0, i2c_addr}, {24'd0, ea});
        chk("i2c_cmd_cap", {24'd0, i2c_cmd}, {24'd0, ec});
        chk("i2c_tx_cap", {24'd0, i2c_tx_data}, {24'd0, ew});
        wait_rsp();
        chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, v.eready});
        chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, v.erdata});
        chk("rsp_nack", {31'd0, rsp_nack}, {31'd0, v.enack});
        chk("rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        chk("i2c_addr_held", {24'd0, i2c_addr}, {24'd0, ea});
    endtask

    initial begin
        int cnt, seen;
        tbl[0] = '{2'b01, 8'h90, 8'h01, 8'h5A, 8'h00, 8'h00, 8'h00, 8'hEE, 1'b0, 2'b01, 8'h00, 1'b0};
        tbl[1] = '{2'b10, 8'h00, 8'h00, 8'h00, 8'h91, 8'h20, 8'h00, 8'hC3, 1'b1, 2'b10, 8'hC3, 1'b1};
        tbl[2] = '{2'b11, 8'hA0, 8'h11, 8'h22, 8'hB1, 8'h33, 8'h44, 8'h77, 1'b0, 2'b01, 8'h00, 1'b0};
        tbl[3] = '{2'b11, 8'hA0, 8'h11, 8'h22, 8'hB1, 8'h33, 8'h44, 8'h5C, 1'b0, 2'b10, 8'h5C, 1'b0};
        tbl[4] = '{2'b11, 8'hA2, 8'h12, 8'h23, 8'hB3, 8'h34, 8'h45, 8'h66, 1'b1, 2'b01, 8'h00, 1'b1};
        tbl[5] = '{2'b11, 8'hA2, 8'h12, 8'h23, 8'hB3, 8'h34, 8'h45, 8'h3E, 1'b0, 2'b10, 8'h3E, 1'b0};
        req_valid = 2'b11;
        #13;
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_trigger", {31'd0, i2c_trigger}, 32'd0);
        chk("rst_i2c_addr", {24'd0, i2c_addr}, 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) run_vec(tbl[i]);
        // master never responds: abort after the ISSUE watchdog
        mode = 1;
        req_valid = 2'b01;
        req_addr = 16'h0040;
        wait_ready();
        chk("tmo_issue_ready", {30'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 2'b00;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i2c_trigger) cnt++;
            else break;
        end
        chk("tmo_issue_trig_cycles", cnt, 32'd17);
        chk("tmo_issue_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        chk("tmo_issue_flag", {31'd0, rsp_timeout}, 32'd1);
        mode = 0;
        run_vec(tbl[0]);
        // busy stuck high: RUN watchdog abort, then no grant until busy falls
        mode = 1;
        req_valid = 2'b01;
        req_addr = 16'h5572;
        wait_ready();
        chk("stuck_ready0", {30'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        busy_force = 1'b1;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready != 0) seen++;
            if (rsp_valid != 0) break;
        end
        chk("stuck_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        chk("stuck_timeout", {31'd0, rsp_timeout}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready != 0) seen++;
        end
        chk("stuck_no_grant", seen, 32'd0);
        busy_force = 1'b0;
        mode = 0;
        wait_ready();
        chk("stuck_late_ready", {30'd0, req_ready}, 32'd2);
        @(posedge clk);
        #1 req_valid = 2'b00;
        wait_rsp();
        chk("stuck_late_rsp", {30'd0, rsp_valid}, 32'd2);
        chk("stuck_late_timeout", {31'd0, rsp_timeout}, 32'd0);
        // reset during RUN drops the transaction silently
        req_valid = 2'b01;
        req_addr = 16'h0090;
        wait_ready();
        chk("rrun_ready", {30'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 2'b00;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!i2c_trigger) break;
        end
        req_valid = 2'b11;
        #2 reset_n = 1'b0;
        #1;
        chk("rrun_trigger", {31'd0, i2c_trigger}, 32'd0);
        chk("rrun_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rrun_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rrun_i2c_addr", {24'd0, i2c_addr}, 32'd0);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid != 0) seen++;
        end
        chk("rrun_no_rsp", seen, 32'd0);
        run_vec(tbl[1]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
